// File: rtl/hazard_match_tracker.sv
// Register-address tracker for the hazard unit: carries Decode register numbers
// through Execute/Memory/Writeback, raises forwarding/stall match bits, counts events.
module hazard_match_tracker #(
    parameter int ADDR_W = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              CondExE,
    input  logic              StallD,
    input  logic              FlushE,
    output logic              Match_1E_M,
    output logic              Match_1E_W,
    output logic              Match_2E_M,
    output logic              Match_2E_W,
    output logic              Match_12D_E,
    output logic              MemtoRegE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [ADDR_W-1:0] WA3M,
    output logic [ADDR_W-1:0] WA3W,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [ADDR_W-1:0] ra1_e;
    logic [ADDR_W-1:0] ra2_e;
    logic [ADDR_W-1:0] wa3_e;
    logic              reg_write_e;
    logic              valid_e;
    logic              valid_m;
    logic              valid_w;

    // NOTE: sequential state uses <= so every stage samples the pre-edge value of
    // its predecessor; blocking here would collapse E->M->W into a single cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra1_e       <= '0;
            ra2_e       <= '0;
            wa3_e       <= '0;
            reg_write_e <= 1'b0;
            MemtoRegE   <= 1'b0;
            valid_e     <= 1'b0;
        end else if (FlushE) begin
            ra1_e       <= '0;
            ra2_e       <= '0;
            wa3_e       <= '0;
            reg_write_e <= 1'b0;
            MemtoRegE   <= 1'b0;
            valid_e     <= 1'b0;
        end else begin
            ra1_e       <= RA1D;
            ra2_e       <= RA2D;
            wa3_e       <= WA3D;
            reg_write_e <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            valid_e     <= 1'b1;
        end
    end

    // M and W never stall; the condition check is folded into RegWriteM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WA3M      <= '0;
            RegWriteM <= 1'b0;
            valid_m   <= 1'b0;
            WA3W      <= '0;
            RegWriteW <= 1'b0;
            valid_w   <= 1'b0;
        end else begin
            WA3M      <= wa3_e;
            RegWriteM <= reg_write_e & CondExE & valid_e;
            valid_m   <= valid_e;
            WA3W      <= WA3M;
            RegWriteW <= RegWriteM;
            valid_w   <= valid_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && StallCnt != CNT_MAX) StallCnt <= StallCnt + 1'b1;
            if (FlushE && FlushCnt != CNT_MAX) FlushCnt <= FlushCnt + 1'b1;
        end
    end

    // PC reads are never forwarded, so a PC source register never matches.
    assign Match_1E_M  = valid_e & valid_m & (ra1_e == WA3M) & (ra1_e != PC_ADDR);
    assign Match_1E_W  = valid_e & valid_w & (ra1_e == WA3W) & (ra1_e != PC_ADDR);
    assign Match_2E_M  = valid_e & valid_m & (ra2_e == WA3M) & (ra2_e != PC_ADDR);
    assign Match_2E_W  = valid_e & valid_w & (ra2_e == WA3W) & (ra2_e != PC_ADDR);
    assign Match_12D_E = valid_e & (((RA1D == wa3_e) & (RA1D != PC_ADDR)) |
                                    ((RA2D == wa3_e) & (RA2D != PC_ADDR)));

endmodule
